// File: rtl/rx_mac_frame_fifo_if.sv
// AXI-Stream beat bundle used on both sides of the receive frame FIFO.
// The master drives payload and valid; the slave answers with ready.
interface rx_mac_frame_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/rx_mac_frame_fifo.sv
// Receive frame FIFO: stores whole frames speculatively, commits on a clean tlast,
// rolls back bad/oversize/overflowed frames, and keeps saturating frame statistics.
module rx_mac_frame_fifo #(
    parameter int DATA_WIDTH      = 32,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int DEPTH           = 512,
    parameter int MAX_FRAME_WORDS = 384,
    parameter int DROP_BAD_FRAME  = 1,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    rx_mac_frame_fifo_if.slave         s_axis,
    rx_mac_frame_fifo_if.master        m_axis,
    output logic [$clog2(DEPTH):0]     o_fifo_level,
    output logic [CNT_WIDTH-1:0]       o_good_frames,
    output logic [CNT_WIDTH-1:0]       o_bad_frames,
    output logic [CNT_WIDTH-1:0]       o_overflow_frames
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DATA_WIDTH + KEEP_WIDTH + 2;
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] MAX_P    = PW'(MAX_FRAME_WORDS);
    localparam logic          DROP_BAD = (DROP_BAD_FRAME != 0);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WRITE = 2'd1, ST_DROP = 2'd2} wr_state_e;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
        if (en && (v != {CNT_WIDTH{1'b1}})) sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        else                                sat_inc = v;
    endfunction

    logic [1:0]           rst_sync_q;
    logic                 rst_n_s;
    logic [EW-1:0]        ram_q [DEPTH];
    logic [EW-1:0]        rd_entry_q;
    wr_state_e            state_q, state_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        beat_cnt_q, beat_cnt_d, level_q;
    logic [CNT_WIDTH-1:0] good_q, bad_q, ovf_q;
    logic                 rd_valid_q, out_valid_q, out_last_q, out_user_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [KEEP_WIDTH-1:0] out_keep_q;
    logic beat_s, full_s, we_s, good_inc_s, bad_inc_s, ovf_inc_s, out_adv_s, ram_re_s;

    // Reset synchroniser: asserts asynchronously, releases on the clock.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) rst_sync_q <= 2'b00;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_s = rst_sync_q[1];

    // The source cannot be stalled, so ready is tied high.
    assign s_axis.tready = 1'b1;
    assign beat_s    = s_axis.tvalid && (s_axis.tlast || (s_axis.tkeep != '0));
    assign full_s    = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    assign out_adv_s = !out_valid_q || m_axis.tready;
    assign ram_re_s  = (rd_ptr_q != wr_commit_q) && (!rd_valid_q || out_adv_s);
    assign rd_ptr_d  = ram_re_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    // Write FSM next state plus the shared end-of-frame commit/roll-back rule.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        beat_cnt_d  = beat_cnt_q;
        we_s        = 1'b0;
        good_inc_s  = 1'b0;
        bad_inc_s   = 1'b0;
        ovf_inc_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (beat_s && full_s) begin
                    ovf_inc_s = 1'b1;
                    state_d   = s_axis.tlast ? ST_IDLE : ST_DROP;
                end else if (beat_s) begin
                    we_s       = 1'b1;
                    wr_ptr_d   = wr_ptr_q + PTR_ONE;
                    beat_cnt_d = PTR_ONE;
                    state_d    = s_axis.tlast ? ST_IDLE : ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (beat_s && full_s) begin
                    wr_ptr_d  = wr_commit_q;
                    ovf_inc_s = 1'b1;
                    state_d   = s_axis.tlast ? ST_IDLE : ST_DROP;
                end else if (beat_s && !s_axis.tlast && (beat_cnt_q == MAX_P)) begin
                    wr_ptr_d  = wr_commit_q;
                    bad_inc_s = 1'b1;
                    state_d   = ST_DROP;
                end else if (beat_s) begin
                    we_s       = 1'b1;
                    wr_ptr_d   = wr_ptr_q + PTR_ONE;
                    beat_cnt_d = beat_cnt_q + PTR_ONE;
                    state_d    = s_axis.tlast ? ST_IDLE : ST_WRITE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DROP: state_d = (beat_s && s_axis.tlast) ? ST_IDLE : ST_DROP;
            default: state_d = ST_IDLE;
        endcase
        if (we_s && s_axis.tlast && s_axis.tuser && DROP_BAD) begin
            wr_ptr_d  = wr_commit_q;
            bad_inc_s = 1'b1;
        end else if (we_s && s_axis.tlast) begin
            wr_commit_d = wr_ptr_q + PTR_ONE;
            good_inc_s  = !s_axis.tuser;
            bad_inc_s   = s_axis.tuser;
        end else begin
            wr_commit_d = wr_commit_q;
        end
    end

    // Frame storage and its synchronous read register.
    always_ff @(posedge i_clk) begin
        if (we_s) ram_q[wr_ptr_q[AW-1:0]] <= {s_axis.tuser, s_axis.tlast, s_axis.tkeep, s_axis.tdata};
        if (ram_re_s) rd_entry_q <= ram_q[rd_ptr_q[AW-1:0]];
    end

    // Pointers, statistics, and the two-stage read prefetch.
    always_ff @(posedge i_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            level_q     <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            ovf_q       <= '0;
            rd_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
            out_keep_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            level_q     <= wr_commit_d - rd_ptr_d;
            good_q      <= sat_inc(good_q, good_inc_s);
            bad_q       <= sat_inc(bad_q, bad_inc_s);
            ovf_q       <= sat_inc(ovf_q, ovf_inc_s);
            if (ram_re_s)       rd_valid_q <= 1'b1;
            else if (out_adv_s) rd_valid_q <= 1'b0;
            if (out_adv_s) begin
                out_valid_q <= rd_valid_q;
                if (rd_valid_q) {out_user_q, out_last_q, out_keep_q, out_data_q} <= rd_entry_q;
            end
        end
    end

    assign m_axis.tvalid     = out_valid_q;
    assign m_axis.tdata      = out_data_q;
    assign m_axis.tkeep      = out_keep_q;
    assign m_axis.tlast      = out_last_q;
    assign m_axis.tuser      = out_user_q;
    assign o_fifo_level      = level_q;
    assign o_good_frames     = good_q;
    assign o_bad_frames      = bad_q;
    assign o_overflow_frames = ovf_q;
endmodule

// File: tb/tb_rx_mac_frame_fifo.sv
// Bench: two FIFOs (bad frames dropped / forwarded) share one stimulus and are checked
// against a frame-level reference model with directed tables and random traffic.
module tb_rx_mac_frame_fifo;
    localparam int DW = 32, KW = 4, DEPTH = 32, MAXW = 20, EW = DW + KW + 2;

    typedef struct {
        int         len;
        logic [3:0] lkeep;
        logic       bad;
        int         eg;
        int         eb;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b1, m_tready = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
    logic ready_fixed = 1'b0, rand_mode = 1'b0;
    logic [5:0]  level_a, level_b;
    logic [15:0] good_a, bad_a, ovf_a;
    logic [3:0]  good_b, bad_b, ovf_b;
    int n_checks = 0, n_fail = 0, cyc = 0, tlast_cyc = 0, rise_cyc = 0;
    int m_good = 0, m_bad = 0, m_ovf = 0;
    logic [EW-1:0] exp_q [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rx_mac_frame_fifo_if #(.DATA_WIDTH(DW)) s_a (), m_a (), s_b (), m_b ();
    assign s_a.tdata = s_tdata;  assign s_a.tkeep = s_tkeep;  assign s_a.tvalid = s_tvalid;
    assign s_a.tlast = s_tlast;  assign s_a.tuser = s_tuser;  assign m_a.tready = m_tready;
    assign s_b.tdata = s_tdata;  assign s_b.tkeep = s_tkeep;  assign s_b.tvalid = s_tvalid;
    assign s_b.tlast = s_tlast;  assign s_b.tuser = s_tuser;  assign m_b.tready = m_tready;

    rx_mac_frame_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_FRAME_WORDS(MAXW),
                        .DROP_BAD_FRAME(1), .CNT_WIDTH(16)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .s_axis(s_a), .m_axis(m_a),
        .o_fifo_level(level_a), .o_good_frames(good_a), .o_bad_frames(bad_a),
        .o_overflow_frames(ovf_a));

    rx_mac_frame_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_FRAME_WORDS(MAXW),
                        .DROP_BAD_FRAME(0), .CNT_WIDTH(4)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .s_axis(s_b), .m_axis(m_b),
        .o_fifo_level(level_b), .o_good_frames(good_b), .o_bad_frames(bad_b),
        .o_overflow_frames(ovf_b));

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", name, act, req);
        end
    endfunction

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic ready_drv();
        forever begin
            @(posedge clk); #1;
            m_tready = rand_mode ? ($urandom_range(0, 9) < 7) : ready_fixed;
        end
    endtask

    // Output scoreboard plus hold-under-backpressure check for both FIFOs.
    task automatic monitor();
        logic [EW-1:0] got [2];
        logic [EW-1:0] prev [2];
        logic vld [2];
        logic hold [2];
        logic prev_v0;
        logic [EW-1:0] e;
        hold[0] = 1'b0; hold[1] = 1'b0; prev[0] = '0; prev[1] = '0; prev_v0 = 1'b0;
        forever begin
            @(negedge clk);
            got[0] = {m_a.tuser, m_a.tlast, m_a.tkeep, m_a.tdata}; vld[0] = m_a.tvalid;
            got[1] = {m_b.tuser, m_b.tlast, m_b.tkeep, m_b.tdata}; vld[1] = m_b.tvalid;
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    hold[d] = 1'b0;
                end else begin
                    if (hold[d])
                        chk(d == 0 ? "a_stall_hold" : "b_stall_hold",
                            64'({vld[d], got[d]}), 64'({1'b1, prev[d]}));
                    if (vld[d] && m_tready) begin
                        if (exp_q[d].size() == 0) begin
                            chk(d == 0 ? "a_extra_beat" : "b_extra_beat", 64'(vld[d]), 64'd0);
                        end else begin
                            e = exp_q[d].pop_front();
                            chk(d == 0 ? "a_beat" : "b_beat", 64'(got[d]), 64'(e));
                        end
                    end
                    hold[d] = vld[d] && !m_tready;
                    prev[d] = got[d];
                end
            end
            if (vld[0] && !prev_v0) rise_cyc = cyc;
            prev_v0 = vld[0];
        end
    endtask

    task automatic send_frame(input int len, input logic [KW-1:0] lkeep, input logic bad,
                              input logic ovf, input logic rnd);
        logic [EW-1:0] fr [$];
        int i;
        i = 0;
        while (i < len) begin
            @(posedge clk); #1;
            if (rnd && ($urandom_range(0, 9) < 2)) begin
                s_tvalid = 1'b0;
            end else if (rnd && ($urandom_range(0, 9) == 0)) begin
                s_tvalid = 1'b1; s_tkeep = '0; s_tlast = 1'b0;
                s_tuser = 1'($urandom_range(0, 1)); s_tdata = $urandom;
            end else begin
                s_tvalid = 1'b1; s_tdata = $urandom; s_tlast = (i == len - 1);
                s_tkeep = s_tlast ? lkeep : {KW{1'b1}};
                s_tuser = s_tlast ? bad : 1'b0;
                fr.push_back({s_tuser, s_tlast, s_tkeep, s_tdata});
                i++;
            end
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = '0; s_tuser = 1'b0;
        tlast_cyc = cyc;
        // Frame-level reference: decide the fate of the whole frame.
        if (ovf) begin
            m_ovf++;
        end else if (len > MAXW + 1) begin
            m_bad++;
        end else begin
            if (bad) m_bad++; else m_good++;
            foreach (fr[k]) begin
                if (!bad) exp_q[0].push_back(fr[k]);
                exp_q[1].push_back(fr[k]);
            end
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && w < 3000) begin
            @(posedge clk); w++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("drain_a_left", 64'(exp_q[0].size()), 64'd0);
        chk("drain_b_left", 64'(exp_q[1].size()), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_a"}, 64'({m_a.tvalid, m_a.tlast, m_a.tuser, m_a.tkeep, m_a.tdata}), 64'd0);
        chk({tag, "_out_b"}, 64'({m_b.tvalid, m_b.tlast, m_b.tuser, m_b.tkeep, m_b.tdata}), 64'd0);
        chk({tag, "_level"}, 64'({level_a, level_b}), 64'd0);
        chk({tag, "_cnt_a"}, 64'({good_a, bad_a, ovf_a}), 64'd0);
        chk({tag, "_cnt_b"}, 64'({good_b, bad_b, ovf_b}), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [11];
        int len, w, mx;
        logic bad;
        logic [3:0] lk;
        vt[0]  = '{16, 4'h3, 1'b0, 1, 0};
        vt[1]  = '{15, 4'hF, 1'b0, 2, 0};
        vt[2]  = '{15, 4'h1, 1'b1, 2, 1};
        vt[3]  = '{15, 4'hF, 1'b0, 3, 1};
        vt[4]  = '{24, 4'hF, 1'b0, 3, 2};
        vt[5]  = '{4,  4'h7, 1'b0, 4, 2};
        vt[6]  = '{1,  4'h1, 1'b0, 5, 2};
        vt[7]  = '{1,  4'hF, 1'b1, 5, 3};
        vt[8]  = '{21, 4'hF, 1'b0, 6, 3};
        vt[9]  = '{22, 4'hF, 1'b0, 6, 4};
        vt[10] = '{20, 4'hF, 1'b0, 7, 4};

        fork
            ready_drv();
            monitor();
        join_none

        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_zero("post_reset");

        ready_fixed = 1'b1;
        for (int i = 0; i < 11; i++) begin
            send_frame(vt[i].len, vt[i].lkeep, vt[i].bad, 1'b0, 1'b0);
            drain();
            if (i == 0) chk("commit_latency", 64'(rise_cyc - tlast_cyc), 64'd2);
            chk($sformatf("tbl%0d_good_a", i), 64'(good_a), 64'(vt[i].eg));
            chk($sformatf("tbl%0d_bad_a", i),  64'(bad_a),  64'(vt[i].eb));
            chk($sformatf("tbl%0d_good_b", i), 64'(good_b), 64'(vt[i].eg));
            chk($sformatf("tbl%0d_bad_b", i),  64'(bad_b),  64'(vt[i].eb));
            chk($sformatf("tbl%0d_level", i),  64'({level_a, level_b}), 64'd0);
            chk($sformatf("tbl%0d_ovf", i),    64'({ovf_a, ovf_b}), 64'd0);
        end

        // Overflow: first frame fits, second overruns storage while output is stalled.
        ready_fixed = 1'b0;
        repeat (2) @(posedge clk);
        send_frame(20, 4'hF, 1'b0, 1'b0, 1'b0);
        send_frame(20, 4'hF, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_cnt_a", 64'(ovf_a), 64'd1);
        chk("ovf_cnt_b", 64'(ovf_b), 64'd1);
        chk("ovf_valid_held", 64'(m_a.tvalid), 64'd1);
        ready_fixed = 1'b1;
        drain();
        send_frame(5, 4'h3, 1'b0, 1'b0, 1'b0);
        drain();
        chk("ovf_after_good_a", 64'(good_a), 64'd9);
        chk("ovf_after_good_b", 64'(good_b), 64'd9);
        chk("ovf_after_level", 64'({level_a, level_b}), 64'd0);

        // Random frames with gaps, ignored beats and random back-pressure.
        rand_mode = 1'b1;
        for (int f = 0; f < 100; f++) begin
            len = $urandom_range(1, 26);
            bad = ($urandom_range(0, 7) == 0);
            lk  = 4'($urandom_range(1, 15));
            w = 0;
            mx = (exp_q[1].size() > exp_q[0].size()) ? exp_q[1].size() : exp_q[0].size();
            while (mx + len > DEPTH && w < 5000) begin
                @(posedge clk); w++;
                mx = (exp_q[1].size() > exp_q[0].size()) ? exp_q[1].size() : exp_q[0].size();
            end
            if (w >= 5000) chk("flow_wait_timeout", 64'(w), 64'd0);
            send_frame(len, lk, bad, 1'b0, 1'b1);
        end
        rand_mode = 1'b0;
        drain();
        chk("rand_good_a", 64'(good_a), 64'(m_good));
        chk("rand_bad_a",  64'(bad_a),  64'(m_bad));
        chk("rand_ovf_a",  64'(ovf_a),  64'(m_ovf));
        chk("rand_good_b_sat", 64'(good_b), 64'(sat4(m_good)));
        chk("rand_bad_b_sat",  64'(bad_b),  64'(sat4(m_bad)));
        chk("rand_level", 64'({level_a, level_b}), 64'd0);

        // Reset while a frame is held at the output and another is half written.
        ready_fixed = 1'b0;
        repeat (2) @(posedge clk);
        send_frame(8, 4'hF, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 chk("pre_rst_valid_a", 64'(m_a.tvalid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            s_tvalid = 1'b1; s_tdata = $urandom; s_tkeep = 4'hF; s_tlast = 1'b0; s_tuser = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b0; s_tvalid = 1'b0;
        #1 check_zero("mid_reset");
        exp_q[0].delete(); exp_q[1].delete();
        m_good = 0; m_bad = 0; m_ovf = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        ready_fixed = 1'b1;
        send_frame(10, 4'h7, 1'b0, 1'b0, 1'b0);
        drain();
        chk("after_rst_good_a", 64'(good_a), 64'd1);
        chk("after_rst_good_b", 64'(good_b), 64'd1);
        chk("after_rst_level", 64'({level_a, level_b}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
